// File: rtl/common_pkg.sv
// Shared bus-level types: 64-bit word, byte strobe, and the data-bus
// request/response records used between the memory stage and the data cache.
package common;

  typedef logic [63:0] u64;
  typedef logic [7:0]  strobe_t;

  typedef struct packed {
    logic       valid;
    u64         addr;
    logic [2:0] size;
    strobe_t    strobe;
    u64         data;
  } dbus_req_t;

  typedef struct packed {
    logic addr_ok;
    logic data_ok;
    u64   data;
  } dbus_resp_t;

endpackage

// File: rtl/pipes_pkg.sv
// Pipeline latch records for the EX/MEM and MEM/WB boundaries, plus the
// access-size encoding and its byte-mask helper.
package pipes;
  import common::*;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef struct packed {
    logic [31:0] instr;
    u64          pc;
    logic        valid;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    msize_t      msize;
    u64          aluout;
    u64          writedata;
    logic [4:0]  dst;
  } execute_data_t;

  typedef struct packed {
    logic [31:0] instr;
    u64          pc;
    logic        valid;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    u64          aluout;
    u64          readdata;
    logic [4:0]  dst;
  } memory_data_t;

  // Unshifted byte-enable mask for an access of the given size.
  function automatic strobe_t sizeMask(msize_t size);
    case (size)
      MSIZE1:  return 8'h01;
      MSIZE2:  return 8'h03;
      MSIZE4:  return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/memory_if.sv
// Data-bus interface between the memory stage (master) and the data cache (slave).
interface memory_if;
  import common::*;

  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);

endinterface

// File: rtl/memory_memalign.sv
// Byte-lane alignment: store strobe/data placement, load extraction with
// zero-extension, and natural-alignment check for an access.
module memalign
  import common::*, pipes::*;
(
  input  logic [2:0] offset,
  input  msize_t     size,
  input  u64         rawData,
  output strobe_t    strobe,
  output u64         shiftedData,
  output logic       misaligned,
  output u64         readData
);

  logic [5:0] bitShift;
  u64         widthMask;
  u64         rightShifted;

  assign bitShift = {offset, 3'b000};

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    widthMask  = '1;
    misaligned = 1'b0;
    case (size)
      MSIZE1: widthMask = 64'h0000_0000_0000_00FF;
      MSIZE2: begin
        widthMask  = 64'h0000_0000_0000_FFFF;
        misaligned = offset[0];
      end
      MSIZE4: begin
        widthMask  = 64'h0000_0000_FFFF_FFFF;
        misaligned = |offset[1:0];
      end
      MSIZE8: misaligned = |offset;
      default: ;
    endcase
  end

  assign strobe       = sizeMask(size) << offset;
  assign shiftedData  = rawData << bitShift;
  assign rightShifted = rawData >> bitShift;
  assign readData     = rightShifted & widthMask;

endmodule

// File: rtl/memory.sv
// Memory pipeline stage: issues one data-bus transaction per load/store,
// stalls upstream until the response, and emits a single valid result.
module memory
  import common::*, pipes::*;
(
  input  logic          clk,
  input  logic          reset,
  input  execute_data_t dataE,
  output memory_data_t  dataM,
  memory_if.master      dbus,
  output logic          stallM,
  output logic          misalign
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t     state, nextState;
  u64         reqAddr, reqData, readdataReg;
  msize_t     reqSize;
  strobe_t    reqStrobe;
  logic       misFlag;

  logic       memOp;
  logic [2:0] alignOffset;
  msize_t     alignSize;
  u64         alignRaw;
  strobe_t    alignStrobe;
  u64         alignWdata;
  logic       alignMis;
  u64         alignRdata;

  assign memOp = dataE.valid & (dataE.memread | dataE.memwrite);

  // IDLE aligns the incoming store data; later states align the bus response.
  always_comb begin
    alignOffset = reqAddr[2:0];
    alignSize   = reqSize;
    alignRaw    = dbus.dresp.data;
    if (state == IDLE) begin
      alignOffset = dataE.aluout[2:0];
      alignSize   = dataE.msize;
      alignRaw    = dataE.writedata;
    end
  end

  memalign uAlign (
    .offset      (alignOffset),
    .size        (alignSize),
    .rawData     (alignRaw),
    .strobe      (alignStrobe),
    .shiftedData (alignWdata),
    .misaligned  (alignMis),
    .readData    (alignRdata)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state       <= IDLE;
      reqAddr     <= '0;
      reqSize     <= MSIZE1;
      reqStrobe   <= '0;
      reqData     <= '0;
      readdataReg <= '0;
      misFlag     <= 1'b0;
    end else begin
      state <= nextState;
      case (state)
        IDLE: if (memOp) begin
          reqAddr     <= dataE.aluout;
          reqSize     <= dataE.msize;
          reqStrobe   <= dataE.memwrite ? alignStrobe : '0;
          reqData     <= dataE.memwrite ? alignWdata : '0;
          readdataReg <= '0;
          misFlag     <= alignMis;
        end
        WAIT: if (dbus.dresp.data_ok) begin
          readdataReg <= dataE.memwrite ? '0 : alignRdata;
        end
        DONE: misFlag <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    nextState      = state;
    stallM         = 1'b0;
    dataM.instr    = dataE.instr;
    dataM.pc       = dataE.pc;
    dataM.valid    = dataE.valid;
    dataM.regwrite = dataE.regwrite;
    dataM.memread  = dataE.memread;
    dataM.memwrite = dataE.memwrite;
    dataM.memtoreg = dataE.memtoreg;
    dataM.aluout   = dataE.aluout;
    dataM.readdata = '0;
    dataM.dst      = dataE.dst;
    case (state)
      IDLE: if (memOp) begin
        stallM      = 1'b1;
        dataM.valid = 1'b0;
        nextState   = alignMis ? DONE : WAIT;
      end
      WAIT: begin
        stallM      = 1'b1;
        dataM.valid = 1'b0;
        if (dbus.dresp.data_ok) nextState = DONE;
      end
      DONE: begin
        dataM.valid    = 1'b1;
        dataM.readdata = readdataReg;
        dataM.regwrite = dataE.regwrite & ~misFlag;
        nextState      = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  assign misalign = (state == DONE) & misFlag;

  always_comb begin
    dbus.dreq.valid  = (state == WAIT);
    dbus.dreq.addr   = reqAddr;
    dbus.dreq.size   = {1'b0, reqSize};
    dbus.dreq.strobe = reqStrobe;
    dbus.dreq.data   = reqData;
  end

endmodule

// File: tb/tb_memory.sv
// Self-checking bench for the memory stage: directed cases followed by random
// loads/stores checked against a byte-level reference of the access rules.
module tb_memory;
  import common::*, pipes::*;

  logic          clk;
  logic          reset;
  execute_data_t dataE;
  memory_data_t  dataM;
  logic          stallM;
  logic          misalign;
  int            tests;
  int            failed;

  memory_if bus ();

  memory dut (
    .clk      (clk),
    .reset    (reset),
    .dataE    (dataE),
    .dataM    (dataM),
    .dbus     (bus),
    .stallM   (stallM),
    .misalign (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference: bytes covered by the access, and whether it is naturally aligned.
  function automatic int numBytes(msize_t sz);
    return 1 << int'(sz);
  endfunction

  function automatic strobe_t refStrobe(u64 addr, msize_t sz);
    strobe_t s;
    int off;
    s = '0;
    off = int'(addr % 8);
    for (int i = 0; i < 8; i++)
      if (i >= off && i < off + numBytes(sz)) s[i] = 1'b1;
    return s;
  endfunction

  function automatic u64 refLoad(u64 addr, msize_t sz, u64 resp);
    u64 r;
    int off;
    r = '0;
    off = int'(addr % 8);
    for (int i = 0; i < numBytes(sz); i++)
      r[8*i +: 8] = resp[8*(off+i) +: 8];
    return r;
  endfunction

  // Drives one access to completion, acting as the bus slave with the given latency.
  task automatic access(input bit isStore, input u64 addr, input msize_t sz, input u64 wd,
                        input u64 resp, input int lat, input bit rw, input string tag);
    bit mis;
    u64 expRd;
    mis   = (addr % u64'(numBytes(sz))) != 0;
    expRd = (isStore || mis) ? '0 : refLoad(addr, sz, resp);

    @(posedge clk); #1;
    dataE.instr     = $urandom;
    dataE.pc        = {$urandom, $urandom};
    dataE.valid     = 1'b1;
    dataE.regwrite  = rw;
    dataE.memread   = !isStore;
    dataE.memwrite  = isStore;
    dataE.memtoreg  = !isStore;
    dataE.msize     = sz;
    dataE.aluout    = addr;
    dataE.writedata = wd;
    dataE.dst       = 5'($urandom);
    bus.dresp       = '0;
    @(negedge clk);
    check({tag, ".idle.stall"}, 64'(stallM), 64'd1);
    check({tag, ".idle.mvalid"}, 64'(dataM.valid), 64'd0);
    check({tag, ".idle.dvalid"}, 64'(bus.dreq.valid), 64'd0);

    if (!mis) begin
      for (int k = 0; k < lat; k++) begin
        @(posedge clk); #1;
        bus.dresp.addr_ok = 1'b1;
        bus.dresp.data_ok = (k == lat - 1);
        bus.dresp.data    = (k == lat - 1) ? resp : {$urandom, $urandom};
        @(negedge clk);
        check({tag, ".wait.dvalid"}, 64'(bus.dreq.valid), 64'd1);
        check({tag, ".wait.addr"}, bus.dreq.addr, addr);
        check({tag, ".wait.size"}, 64'(bus.dreq.size), 64'(sz));
        check({tag, ".wait.strobe"}, 64'(bus.dreq.strobe), isStore ? 64'(refStrobe(addr, sz)) : 64'd0);
        if (isStore) check({tag, ".wait.data"}, bus.dreq.data, wd << (8 * (addr % 8)));
        check({tag, ".wait.stall"}, 64'(stallM), 64'd1);
        check({tag, ".wait.mvalid"}, 64'(dataM.valid), 64'd0);
      end
    end

    @(posedge clk); #1;
    bus.dresp = '0;
    @(negedge clk);
    check({tag, ".done.mvalid"}, 64'(dataM.valid), 64'd1);
    check({tag, ".done.readdata"}, dataM.readdata, expRd);
    check({tag, ".done.regwrite"}, 64'(dataM.regwrite), 64'(rw && !mis));
    check({tag, ".done.aluout"}, dataM.aluout, addr);
    check({tag, ".done.dst"}, 64'(dataM.dst), 64'(dataE.dst));
    check({tag, ".done.stall"}, 64'(stallM), 64'd0);
    check({tag, ".done.misalign"}, 64'(misalign), 64'(mis));
    check({tag, ".done.dvalid"}, 64'(bus.dreq.valid), 64'd0);

    @(posedge clk); #1;
    dataE.valid = 1'b0;
    @(negedge clk);
    check({tag, ".after.mvalid"}, 64'(dataM.valid), 64'd0);
    check({tag, ".after.misalign"}, 64'(misalign), 64'd0);
  endtask

  initial begin
    tests     = 0;
    failed    = 0;
    reset     = 1'b0;
    dataE     = '0;
    bus.dresp = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.dvalid", 64'(bus.dreq.valid), 64'd0);
    check("reset.stall", 64'(stallM), 64'd0);
    check("reset.misalign", 64'(misalign), 64'd0);
    check("reset.mvalid", 64'(dataM.valid), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // ALU op passes straight through.
    dataE.valid    = 1'b1;
    dataE.regwrite = 1'b1;
    dataE.aluout   = 64'h1234;
    dataE.dst      = 5'd7;
    @(negedge clk);
    check("alu.mvalid", 64'(dataM.valid), 64'd1);
    check("alu.aluout", dataM.aluout, 64'h1234);
    check("alu.readdata", dataM.readdata, 64'd0);
    check("alu.stall", 64'(stallM), 64'd0);
    check("alu.dvalid", 64'(bus.dreq.valid), 64'd0);
    @(posedge clk); #1;
    dataE.valid = 1'b0;

    // Directed accesses.
    access(1'b0, 64'h80, MSIZE8, 64'd0, 64'hDEAD_BEEF_CAFE_BABE, 3, 1'b1, "ld8");
    access(1'b0, 64'h83, MSIZE1, 64'd0, 64'h0000_0000_AB00_0000, 1, 1'b1, "ld1");
    access(1'b1, 64'h86, MSIZE2, 64'h1122, 64'hFFFF_FFFF_FFFF_FFFF, 2, 1'b0, "st2");
    access(1'b1, 64'h84, MSIZE4, 64'h5566_7788, 64'h1, 1, 1'b0, "st4");
    access(1'b0, 64'h82, MSIZE4, 64'd0, 64'h1234_5678_9ABC_DEF0, 1, 1'b1, "mis4");

    // Reset while waiting abandons the access; a later data_ok is ignored.
    @(posedge clk); #1;
    dataE.valid    = 1'b1;
    dataE.memread  = 1'b1;
    dataE.memwrite = 1'b0;
    dataE.regwrite = 1'b1;
    dataE.msize    = MSIZE8;
    dataE.aluout   = 64'h100;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst.wait.dvalid", 64'(bus.dreq.valid), 64'd1);
    @(posedge clk); #1;
    reset             = 1'b1;
    dataE.valid       = 1'b0;
    bus.dresp.data_ok = 1'b1;
    bus.dresp.data    = 64'hAAAA_5555_AAAA_5555;
    @(negedge clk);
    check("rst.dvalid", 64'(bus.dreq.valid), 64'd0);
    check("rst.stall", 64'(stallM), 64'd0);
    check("rst.mvalid", 64'(dataM.valid), 64'd0);
    @(posedge clk); #1;
    bus.dresp = '0;
    @(negedge clk);
    check("rst.next.mvalid", 64'(dataM.valid), 64'd0);
    check("rst.next.dvalid", 64'(bus.dreq.valid), 64'd0);
    check("rst.next.misalign", 64'(misalign), 64'd0);

    // Random loads and stores.
    for (int n = 0; n < 40; n++) begin
      msize_t sz;
      u64     addr;
      sz   = msize_t'($urandom_range(3));
      addr = {$urandom, $urandom};
      if ($urandom_range(3) != 0) addr = addr & ~u64'(numBytes(sz) - 1);
      access(1'($urandom), addr, sz, {$urandom, $urandom}, {$urandom, $urandom},
             int'($urandom_range(1, 4)), 1'($urandom), $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
